playback_ctrl: RTL and testbench
================================

# playback_ctrl

Playback controller for the audio reproductor. It turns the raw pause/next/previous switches into debounced one-cycle commands and sequences the track loader through a req/ack handshake. It gates the audio sample stream and keeps the elapsed track time (mm:ss), shown on the four 7-segment displays. It sits between the board switches and the audio streamer/loader inside the audiosystem top.

## Interface
- CLK_HZ, 50_000_000: clk_clk frequency; one elapsed second = CLK_HZ cycles.
- DEBOUNCE_CYC, 1_000_000: cycles a synchronized switch level must stay stable before it is accepted.
- N_TRACKS, 4: number of tracks, >= 2; TW = clog2(N_TRACKS).
- RESTART_S, 3: on "previous", if elapsed seconds >= RESTART_S, restart the current track instead.
- clk_clk  in  1  single system clock.
- reset_reset_n  in  1  reset, synchronous, active-low.
- pausa_sw_export, siguiente_sw_export, anterior_sw_export  in  1 each  raw switches, active-high, asynchronous to clk_clk.
- load_req  out  1  request the loader to rewind the streamer to the start of load_track.
- load_track  out  TW  track to load; stable while load_req is high.
- load_ack  in  1  loader completion; sampled only while load_req is high.
- track_end  in  1  one-cycle pulse from the streamer at the last sample of a track.
- play_en  out  1  enables the sample stream to the DAC.
- track_idx  out  TW  current track.
- min1_export, min2_export, seg1_export, seg2_export  out  7 each  7-segment digits: minute tens, minute units, second tens, second units. Segments are active-low, bit0 = a … bit6 = g.

## Operation
- Each switch goes through a 2-flop synchronizer and then a debouncer. The debouncer emits a one-cycle pulse on an accepted 0→1 transition only.
- The controller is an FSM with three states: LOAD, PLAY, PAUSE. A flag `paused` records the user's pause choice.
- LOAD:
  - load_req is high and load_track equals track_idx.
  - When load_ack is high: load_req drops on the next edge, mm:ss and the prescaler clear, and the FSM moves to PAUSE if paused = 1, otherwise to PLAY.
- PLAY: play_en = 1 and the prescaler counts.
- PAUSE: play_en = 0 and the prescaler holds its value (it is not cleared).
- Pause pulse: toggles `paused` in any state. In PLAY it moves to PAUSE; in PAUSE it moves to PLAY; in LOAD only the flag changes.
- Next pulse, in PLAY or PAUSE: track_idx ← (track_idx + 1) mod N_TRACKS, then go to LOAD.
- Prev pulse, in PLAY or PAUSE:
  - If elapsed ≥ RESTART_S seconds (any nonzero minutes counts): keep track_idx.
  - Otherwise: track_idx ← (track_idx − 1) mod N_TRACKS, so 0 wraps to N_TRACKS−1.
  - Either way, go to LOAD.
- track_end in PLAY behaves exactly like a next pulse. It is ignored in PAUSE and LOAD.
- Next, prev and track_end pulses arriving during LOAD are dropped.
- Next and prev in the same cycle: both are dropped. A pause pulse in that same cycle is still applied.
- A pause pulse together with next, prev or track_end in the same cycle: both take effect.
- Elapsed time:
  - When the prescaler reaches CLK_HZ−1 it wraps to 0 and seconds increment.
  - Seconds run 0..59; the step 59→0 increments minutes.
  - Minutes run 0..99 and saturate: once 99:59 is reached, the time holds there.
  - Digits are stored in BCD and decoded combinationally to the 7-segment outputs.

## Timing
- All state changes happen on the clk_clk rising edge.
- Reset values: state = LOAD, load_req = 0, load_track = 0, track_idx = 0, paused = 0, play_en = 0, prescaler = 0, time = 00:00.
  - Each display shows "0" (7'b1000000).
  - load_req rises on the first edge after reset deasserts.
- Switch to command latency: DEBOUNCE_CYC + 3 cycles from the first stable raw level to the command pulse.
- Command pulse to outputs: one cycle. The edge that samples a pulse updates state, play_en, track_idx and load_req together.
- Handshake: load_req is held until load_ack is sampled high. load_ack is ignored while load_req is low. The loader may assert load_ack in the same cycle load_req rises.
- Reset asserted mid-LOAD: load_req drops at that edge and the load restarts on track 0 after reset is released.
- The 7-segment outputs are combinational from registered BCD, so there is no extra latency.

## Structure
- playback_pkg holds:
  - the state enum (LOAD, PLAY, PAUSE);
  - the seven-segment encode function (BCD → 7 bits, active-low; codes 10–15 show blank, 7'h7F);
  - the constant SEG_ZERO.
- One sub-module, sw_debounce: 2-flop synchronizer, stability counter, rising-edge pulse. It is instantiated three times.
- The top level holds the FSM, the track index, the prescaler and the BCD time counter.

## Test plan
Bench parameters: CLK_HZ=10, DEBOUNCE_CYC=4, N_TRACKS=4, RESTART_S=3.
- Reset release, loader acks 2 cycles after request → load_req high for 3 cycles, load_track=0, then PLAY with play_en=1 and displays 00:00.
- PLAY for 600 cycles → display 01:00 (digits 0,1,0,0); pause pulse → play_en=0 and the time holds for 100 cycles; pause again → counting resumes from the held prescaler value.
- track_idx=3, next pulse → load_track=0 (wrap), time cleared after ack; the same from PAUSE leaves the FSM in PAUSE after ack with play_en=0.
- Prev at elapsed 00:02 on track 0 → load_track=3; prev at 00:05 on track 2 → load_track=2 (restart).
- Next and prev in the same cycle → no load; pause and next in the same cycle → load of track+1 and PAUSE afterwards; track_end during PAUSE → ignored.
- Reset asserted while load_req is high → load_req=0 next edge and all outputs at reset values; a bounce shorter than 4 cycles → no command; run to 99:59 plus 50 more seconds → the display stays at 99:59.

Source files
------------

// File: rtl/playback_pkg.sv
// Shared types and helpers for the playback controller: FSM state encoding,
// the BCD mm:ss time record and the active-low seven-segment encoder.
package playback_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Elapsed time held as four BCD digits, most significant first.
    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_u;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = 16'h0000;
    localparam bcd_time_t TIME_MAX  = 16'h9959;

    // Segment patterns are active-low, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_ZERO;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Switch conditioner: two-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted low-to-high transition. A new level is
// accepted only after it has been seen unchanged for DEBOUNCE_CYC cycles.
module sw_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Bring the asynchronous switch into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level once it has differed from the current one long enough;
    // any return to the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync_q2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_q2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // One-cycle pulse on the accepted rising edge only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

endmodule

// File: rtl/playback_ctrl.sv
// Playback controller: debounced pause/next/previous commands, LOAD/PLAY/PAUSE
// sequencing with a req/ack track loader, sample-stream gating and the
// saturating mm:ss elapsed-time counter driving four seven-segment digits.
module playback_ctrl
    import playback_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int N_TRACKS     = 4,
    parameter int RESTART_S    = 3
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic                        pausa_sw_export,
    input  logic                        siguiente_sw_export,
    input  logic                        anterior_sw_export,
    output logic                        load_req,
    output logic [$clog2(N_TRACKS)-1:0] load_track,
    input  logic                        load_ack,
    input  logic                        track_end,
    output logic                        play_en,
    output logic [$clog2(N_TRACKS)-1:0] track_idx,
    output logic [6:0]                  min1_export,
    output logic [6:0]                  min2_export,
    output logic [6:0]                  seg1_export,
    output logic [6:0]                  seg2_export
);

    localparam int TW = $clog2(N_TRACKS);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [TW-1:0] LAST_TRACK = TW'(N_TRACKS - 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);

    logic          pause_p;
    logic          next_p;
    logic          prev_p;

    state_t        state_q;
    state_t        state_d;
    logic          paused;
    logic          paused_d;
    logic          req_d;
    logic [TW-1:0] track_d;

    logic [PW-1:0] presc;
    bcd_time_t     time_q;
    logic [6:0]    sec_bin;

    logic          next_cmd;
    logic          prev_cmd;
    logic          active;
    logic          ack_ok;
    logic          advance;
    logic          retreat;
    logic          restart_ok;

    // Advance the elapsed time by one second, holding at 99:59.
    function automatic bcd_time_t time_step(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t != TIME_MAX) begin
            if (t.sec_u != 4'd9) begin
                r.sec_u = t.sec_u + 4'd1;
            end else begin
                r.sec_u = 4'd0;
                if (t.sec_t != 4'd5) begin
                    r.sec_t = t.sec_t + 4'd1;
                end else begin
                    r.sec_t = 4'd0;
                    if (t.min_u != 4'd9) begin
                        r.min_u = t.min_u + 4'd1;
                    end else begin
                        r.min_u = 4'd0;
                        r.min_t = t.min_t + 4'd1;
                    end
                end
            end
        end
        return r;
    endfunction

    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_pause (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .raw   (pausa_sw_export),
        .pulse (pause_p)
    );

    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_next (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .raw   (siguiente_sw_export),
        .pulse (next_p)
    );

    sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_prev (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .raw   (anterior_sw_export),
        .pulse (prev_p)
    );

    // Command qualification. Next and prev together cancel each other; a
    // user prev takes precedence over a simultaneous end-of-track.
    assign next_cmd   = next_p & ~prev_p;
    assign prev_cmd   = prev_p & ~next_p;
    assign active     = (state_q == ST_PLAY) || (state_q == ST_PAUSE);
    assign ack_ok     = (state_q == ST_LOAD) & load_req & load_ack;
    assign retreat    = active & prev_cmd;
    assign advance    = active & (next_cmd | ((state_q == ST_PLAY) & track_end & ~prev_cmd));
    assign paused_d   = paused ^ pause_p;

    assign sec_bin    = {3'b000, time_q.sec_t} * 7'd10 + {3'b000, time_q.sec_u};
    assign restart_ok = (time_q.min_t != 4'd0) || (time_q.min_u != 4'd0) ||
                        (int'(sec_bin) >= RESTART_S);

    // FSM state register.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (ack_ok) begin
                    state_d = paused_d ? ST_PAUSE : ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (advance || retreat) begin
                    state_d = ST_LOAD;
                end else if (pause_p) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (advance || retreat) begin
                    state_d = ST_LOAD;
                end else if (pause_p) begin
                    state_d = ST_PLAY;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // FSM outputs: stream gate from the current state, request from the next.
    always_comb begin
        play_en = (state_q == ST_PLAY);
        req_d   = (state_d == ST_LOAD);
    end

    // Track selection for next/prev, with wrap and the restart rule.
    always_comb begin
        track_d = track_idx;
        if (advance) begin
            track_d = (track_idx == LAST_TRACK) ? '0 : track_idx + 1'b1;
        end else if (retreat && !restart_ok) begin
            track_d = (track_idx == '0) ? LAST_TRACK : track_idx - 1'b1;
        end
    end

    // Control registers: pause flag, track index and loader request.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            paused    <= 1'b0;
            track_idx <= '0;
            load_req  <= 1'b0;
        end else begin
            paused    <= paused_d;
            track_idx <= track_d;
            load_req  <= req_d;
        end
    end

    assign load_track = track_idx;

    // Prescaler and BCD time: cleared on load completion, counting only in PLAY.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            presc  <= '0;
            time_q <= TIME_ZERO;
        end else if (ack_ok) begin
            presc  <= '0;
            time_q <= TIME_ZERO;
        end else if (play_en) begin
            if (presc == PRESC_MAX) begin
                presc  <= '0;
                time_q <= time_step(time_q);
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    assign min1_export = seg7_encode(time_q.min_t);
    assign min2_export = seg7_encode(time_q.min_u);
    assign seg1_export = seg7_encode(time_q.sec_t);
    assign seg2_export = seg7_encode(time_q.sec_u);

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl with small clock/debounce parameters.
// Expected load targets are queued when a command is issued and popped when
// the controller raises load_req.
module tb_playback_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pausa;
    logic       sig;
    logic       ant;
    logic       load_ack;
    logic       track_end;
    logic       load_req;
    logic [1:0] load_track;
    logic       play_en;
    logic [1:0] track_idx;
    logic [6:0] min1;
    logic [6:0] min2;
    logic [6:0] seg1;
    logic [6:0] seg2;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int rise_n;

    playback_ctrl #(
        .CLK_HZ       (10),
        .DEBOUNCE_CYC (D),
        .N_TRACKS     (4),
        .RESTART_S    (3)
    ) dut (
        .clk_clk             (clk),
        .reset_reset_n       (rst_n),
        .pausa_sw_export     (pausa),
        .siguiente_sw_export (sig),
        .anterior_sw_export  (ant),
        .load_req            (load_req),
        .load_track          (load_track),
        .load_ack            (load_ack),
        .track_end           (track_end),
        .play_en             (play_en),
        .track_idx           (track_idx),
        .min1_export         (min1),
        .min2_export         (min2),
        .seg1_export         (seg1),
        .seg2_export         (seg2)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk_time(input string tag, input int mm, input int ss);
        chk(tag, {4'h0, min1, min2, seg1, seg2},
            {4'h0, seg_ref(mm / 10), seg_ref(mm % 10), seg_ref(ss / 10), seg_ref(ss % 10)});
    endtask

    // Loader model: wait for a request, check its target, ack after 'delay' cycles.
    task automatic do_load(input int delay, output int waited);
        int n;
        int e;
        n = 0;
        while (load_req !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        waited = n;
        if (load_req !== 1'b1) chk("load_req_timeout", 32'(load_req), 32'd1);
        e = -1;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("load_track", 32'(load_track), 32'(e));
        step(delay);
        chk("load_req_held", 32'(load_req), 32'd1);
        load_ack = 1'b1;
        step(1);
        load_ack = 1'b0;
        chk("load_req_drop", 32'(load_req), 32'd0);
    endtask

    // m = {anterior, siguiente, pausa}; command pulse is out after D+3 edges.
    task automatic press_start(input logic [2:0] m);
        {ant, sig, pausa} = m;
        step(D + 3);
    endtask

    task automatic press_end();
        step(1);
        {ant, sig, pausa} = 3'b000;
        step(D + 4);
    endtask

    task automatic press(input logic [2:0] m);
        press_start(m);
        press_end();
    endtask

    initial begin
        rst_n = 1'b0;
        {ant, sig, pausa} = 3'b000;
        load_ack = 1'b0;
        track_end = 1'b0;
        step(3);
        chk("rst_load_req", 32'(load_req), 32'd0);
        chk("rst_play_en", 32'(play_en), 32'd0);
        chk("rst_track_idx", 32'(track_idx), 32'd0);
        chk("rst_load_track", 32'(load_track), 32'd0);
        chk_time("rst_display", 0, 0);

        // first load after reset, ack two cycles after the request
        rst_n = 1'b1;
        exp_q.push_back(0);
        do_load(2, rise_n);
        chk("req_rise_latency", 32'(rise_n), 32'd1);
        chk("play_after_load", 32'(play_en), 32'd1);
        chk_time("time_after_load", 0, 0);

        // one minute of play, then pause/resume
        step(600);
        chk_time("one_minute", 1, 0);
        press_start(3'b001);
        chk("pause_latency", 32'(play_en), 32'd1);
        press_end();
        chk("paused_play_en", 32'(play_en), 32'd0);
        step(100);
        chk_time("time_held", 1, 0);
        press(3'b001);
        chk("resumed_play_en", 32'(play_en), 32'd1);
        chk_time("resume_1", 1, 1);
        step(3);
        chk_time("resume_2", 1, 1);
        step(1);
        chk_time("resume_3", 1, 2);

        // step through tracks 1..3 and wrap to 0
        for (int t = 1; t < 4; t++) begin
            exp_q.push_back(t);
            press(3'b010);
            do_load(0, rise_n);
        end
        chk("track_three", 32'(track_idx), 32'd3);
        step(30);
        chk_time("elapsed_3s", 0, 3);
        exp_q.push_back(0);
        press(3'b010);
        do_load(1, rise_n);
        chk("next_wrap", 32'(track_idx), 32'd0);
        chk_time("cleared_after_ack", 0, 0);
        chk("wrap_play_en", 32'(play_en), 32'd1);

        // next from PAUSE returns to PAUSE
        press(3'b001);
        exp_q.push_back(1);
        press(3'b010);
        do_load(2, rise_n);
        chk("pause_next_play_en", 32'(play_en), 32'd0);
        chk("pause_next_track", 32'(track_idx), 32'd1);
        press(3'b001);

        // prev at 00:01 on track 1 -> track 0
        exp_q.push_back(0);
        press(3'b100);
        do_load(0, rise_n);
        chk("prev_to_0", 32'(track_idx), 32'd0);

        // prev at 00:02 on track 0 -> wrap to 3
        step(13);
        press_start(3'b100);
        chk_time("prev_at_2s", 0, 2);
        exp_q.push_back(3);
        press_end();
        do_load(0, rise_n);
        chk("prev_wrap", 32'(track_idx), 32'd3);

        exp_q.push_back(2);
        press(3'b100);
        do_load(0, rise_n);
        chk("prev_to_2", 32'(track_idx), 32'd2);

        // prev at exactly 00:03 and at 00:05 -> restart track 2
        step(23);
        press_start(3'b100);
        chk_time("prev_at_3s", 0, 3);
        exp_q.push_back(2);
        press_end();
        do_load(0, rise_n);
        chk("restart_3s", 32'(track_idx), 32'd2);
        step(43);
        press_start(3'b100);
        chk_time("prev_at_5s", 0, 5);
        exp_q.push_back(2);
        press_end();
        do_load(0, rise_n);
        chk("restart_5s", 32'(track_idx), 32'd2);

        // next and prev together are dropped
        press(3'b110);
        chk("next_prev_no_load", 32'(load_req), 32'd0);
        chk("next_prev_track", 32'(track_idx), 32'd2);
        chk("next_prev_play", 32'(play_en), 32'd1);

        // pause and next together: load track 3, then PAUSE
        exp_q.push_back(3);
        press(3'b011);
        do_load(0, rise_n);
        chk("pause_next_paused", 32'(play_en), 32'd0);
        chk("pause_next_trk", 32'(track_idx), 32'd3);

        // track_end ignored in PAUSE
        track_end = 1'b1;
        step(1);
        track_end = 1'b0;
        step(2);
        chk("tend_pause_req", 32'(load_req), 32'd0);
        chk("tend_pause_track", 32'(track_idx), 32'd3);

        // track_end in PLAY acts as next
        press(3'b001);
        chk("unpause", 32'(play_en), 32'd1);
        exp_q.push_back(0);
        track_end = 1'b1;
        step(1);
        track_end = 1'b0;
        do_load(0, rise_n);
        chk("tend_play_track", 32'(track_idx), 32'd0);

        // reset while a load is pending
        press(3'b010);
        chk("req_before_reset", 32'(load_req), 32'd1);
        rst_n = 1'b0;
        step(1);
        chk("reset_mid_req", 32'(load_req), 32'd0);
        chk("reset_mid_track", 32'(track_idx), 32'd0);
        chk("reset_mid_play", 32'(play_en), 32'd0);
        step(2);
        rst_n = 1'b1;
        exp_q.push_back(0);
        do_load(2, rise_n);
        chk("req_rise_after_reset", 32'(rise_n), 32'd1);
        chk("play_after_reset", 32'(play_en), 32'd1);

        // bounce of 3 cycles rejected, 4 cycles accepted
        pausa = 1'b1;
        step(3);
        pausa = 1'b0;
        step(12);
        chk("bounce_rejected", 32'(play_en), 32'd1);
        pausa = 1'b1;
        step(4);
        pausa = 1'b0;
        step(12);
        chk("min_press_accepted", 32'(play_en), 32'd0);
        press(3'b001);

        // run to 99:59 and beyond
        exp_q.push_back(1);
        press(3'b010);
        do_load(0, rise_n);
        step(59989);
        chk_time("time_99_58", 99, 58);
        step(1);
        chk_time("time_99_59", 99, 59);
        step(500);
        chk_time("time_saturated", 99, 59);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
